// File: rtl/ksa.sv
// RC4 key-scheduling stage: permutes the 256-byte S RAM in place using the captured key.
// Each iteration reads S[i], computes j, reads S[j], then writes both back swapped. One iteration takes 8 cycles.
module ksa #(
    parameter int KEYLEN = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic                  rdy,
    input  logic [8*KEYLEN-1:0]   key,
    output logic [7:0]            s_addr,
    input  logic [7:0]            s_rddata,
    output logic [7:0]            s_wrdata,
    output logic                  s_wren
);

    localparam int KIW = (KEYLEN > 1) ? $clog2(KEYLEN) : 1;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        RDI1  = 4'd1,
        RDI2  = 4'd2,
        CALCJ = 4'd3,
        RDJ1  = 4'd4,
        RDJ2  = 4'd5,
        WRI   = 4'd6,
        WRJ   = 4'd7,
        INCR  = 4'd8
    } state_t;

    state_t              state;
    logic [7:0]          i;
    logic [7:0]          j;
    logic [7:0]          si;
    logic [KIW-1:0]      kidx;
    logic [8*KEYLEN-1:0] key_reg;
    logic [7:0]          key_byte;
    logic [7:0]          j_next;

    // kidx tracks i mod KEYLEN incrementally; byte 0 sits in the top byte of the key.
    always_comb begin
        key_byte = key_reg[8*KEYLEN-1 -: 8];
        for (int b = 0; b < KEYLEN; b++) begin
            if (kidx == KIW'(b)) begin
                key_byte = key_reg[8*(KEYLEN-1-b) +: 8];
            end
        end
    end

    assign j_next = j + si + key_byte;

    // Outputs are registered: each branch loads the values the next state presents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            i        <= 8'd0;
            j        <= 8'd0;
            si       <= 8'd0;
            kidx     <= '0;
            key_reg  <= '0;
            rdy      <= 1'b1;
            s_addr   <= 8'd0;
            s_wrdata <= 8'd0;
            s_wren   <= 1'b0;
        end else begin
            rdy      <= 1'b0;
            s_addr   <= 8'd0;
            s_wrdata <= 8'd0;
            s_wren   <= 1'b0;
            case (state)
                IDLE: begin
                    i    <= 8'd0;
                    j    <= 8'd0;
                    kidx <= '0;
                    if (en) begin
                        key_reg <= key;
                        state   <= RDI1;
                        s_addr  <= 8'd0;
                    end else begin
                        rdy <= 1'b1;
                    end
                end
                RDI1: begin
                    state  <= RDI2;
                    s_addr <= i;
                end
                RDI2: begin
                    si    <= s_rddata;
                    state <= CALCJ;
                end
                CALCJ: begin
                    j      <= j_next;
                    state  <= RDJ1;
                    s_addr <= j_next;
                end
                RDJ1: begin
                    state  <= RDJ2;
                    s_addr <= j;
                end
                RDJ2: begin
                    // S[j] goes straight into the write-data register for the S[i] write.
                    state    <= WRI;
                    s_addr   <= i;
                    s_wrdata <= s_rddata;
                    s_wren   <= 1'b1;
                end
                WRI: begin
                    state    <= WRJ;
                    s_addr   <= j;
                    s_wrdata <= si;
                    s_wren   <= 1'b1;
                end
                WRJ: begin
                    state <= INCR;
                end
                INCR: begin
                    if (i == 8'd255) begin
                        state <= IDLE;
                        rdy   <= 1'b1;
                        i     <= 8'd0;
                        j     <= 8'd0;
                        kidx  <= '0;
                    end else begin
                        state  <= RDI1;
                        i      <= i + 8'd1;
                        s_addr <= i + 8'd1;
                        kidx   <= (kidx == KIW'(KEYLEN-1)) ? '0 : kidx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    rdy   <= 1'b1;
                end
            endcase
        end
    end

endmodule
